// File: rtl/seq_divider_8bit.sv
// Unsigned sequential restoring divider: one quotient bit per clock, MSB first,
// with valid/ready handshakes on both the operand and the result side.
module seq_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] prem_nxt;
  logic             qbit;

  // The partial remainder is always below the divisor, so the difference fits
  // in WIDTH bits; only the comparison needs the extra carry bit.
  always_comb begin
    trial    = {prem, shreg[WIDTH-1]};
    qbit     = (trial >= {1'b0, dvsr});
    diff     = trial[WIDTH-1:0] - dvsr;
    prem_nxt = qbit ? diff : trial[WIDTH-1:0];
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The dividend shift register doubles as the quotient accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prem        <= '0;
      shreg       <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              prem        <= '0;
              shreg       <= dividend;
              dvsr        <= divisor;
              cnt         <= CW'(WIDTH - 1);
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          prem  <= prem_nxt;
          shreg <= {shreg[WIDTH-2:0], qbit};
          cnt   <= cnt - CW'(1);
          if (cnt == '0) begin
            quotient  <= {shreg[WIDTH-2:0], qbit};
            remainder <= prem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Self-checking bench for seq_divider_8bit: directed cases plus a randomized
// back-to-back run checked against plain integer division.
module tb_seq_divider_8bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned q;
    int unsigned r;
    int unsigned z;
  } exp_t;

  exp_t        expq[$];
  bit          busy;
  int unsigned n_acc;
  int unsigned n_res;

  seq_divider_8bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int unsigned a, input int unsigned b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = (1 << W) - 1;
      e.r = a;
      e.z = 1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 0;
    end
    return e;
  endfunction

  // Issue one operation; hold out_ready low for 'hold' cycles once the result appears.
  task automatic run_op(input string tag, input int unsigned a, input int unsigned b,
                        input int unsigned hold);
    exp_t        e;
    int unsigned lat;
    int unsigned guard;
    e         = model(a, b);
    out_ready = (hold == 0);
    dividend  = W'(a);
    divisor   = W'(b);
    in_valid  = 1'b1;
    guard     = 0;
    while (!in_ready && guard < 40) begin
      tick();
      guard++;
    end
    check({tag, "_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat      = 1;
    while (!out_valid && lat < 40) begin
      check({tag, "_busy_rdy"}, in_ready, 0);
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, (b == 0) ? 1 : W + 1);
    check({tag, "_q"}, quotient, e.q);
    check({tag, "_r"}, remainder, e.r);
    check({tag, "_dbz"}, div_by_zero, e.z);
    check({tag, "_rdy_done"}, in_ready, 0);
    for (int i = 0; i < int'(hold); i++) begin
      tick();
      check({tag, "_hold_v"}, out_valid, 1);
      check({tag, "_hold_q"}, quotient, e.q);
      check({tag, "_hold_r"}, remainder, e.r);
      check({tag, "_hold_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_after_v"}, out_valid, 0);
    check({tag, "_after_rdy"}, in_ready, 1);
  endtask

  // One cycle of the randomized run: observe handshakes before the edge, then re-drive.
  task automatic rand_step(input bit drive);
    bit   acc;
    bit   res;
    exp_t e;
    check("rand_rdy", in_ready, !busy);
    acc = in_valid && in_ready;
    res = out_valid && out_ready;
    if (res) begin
      if (expq.size() == 0) begin
        check("rand_extra_result", 1, 0);
      end else begin
        e = expq.pop_front();
        check("rand_q", quotient, e.q);
        check("rand_r", remainder, e.r);
        check("rand_dbz", div_by_zero, e.z);
        if (e.b != 0) begin
          check("rand_identity", quotient * e.b + remainder, e.a);
          check("rand_r_lt_b", remainder < e.b, 1);
        end
      end
      n_res++;
    end
    if (acc) begin
      expq.push_back(model(dividend, divisor));
      n_acc++;
    end
    tick();
    if (acc) busy = 1'b1;
    if (res) busy = 1'b0;
    if (drive) begin
      dividend  = W'($urandom);
      divisor   = ($urandom_range(15) == 0) ? '0 : W'($urandom);
      out_ready = $urandom_range(1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    check("rst_rdy", in_ready, 1);
    check("rst_v", out_valid, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;

    run_op("d200_7", 200, 7, 0);
    run_op("d255_1", 255, 1, 0);
    run_op("d5_9", 5, 9, 0);
    run_op("d0_3", 0, 3, 0);
    run_op("d255_255", 255, 255, 0);
    run_op("d100_0", 100, 0, 0);
    run_op("d9_3", 9, 3, 0);
    run_op("d77_5_bp", 77, 5, 6);

    // Reset during the fourth CALC cycle discards the operation.
    dividend = 8'd200;
    divisor  = 8'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_v", out_valid, 0);
    check("midrst_rdy", in_ready, 1);
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    tick();
    check("midrst_no_result", out_valid, 0);
    run_op("d50_6", 50, 6, 0);

    // Randomized back-to-back run with in_valid held high.
    busy      = 1'b0;
    n_acc     = 0;
    n_res     = 0;
    in_valid  = 1'b1;
    dividend  = W'($urandom);
    divisor   = W'($urandom);
    out_ready = $urandom_range(1);
    for (int c = 0; c < 30000; c++) rand_step(1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) rand_step(1'b0);
    check("rand_drained", expq.size(), 0);
    check("rand_counts", n_res, n_acc);
    check("rand_some_ops", n_acc > 1000, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
